// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared definitions for the MIPS MEM/WB slice: data and register
//            widths, write-back bundle width, memory access size encodings and
//            helpers that build byte-lane enables and lane-replicated store
//            data.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_W       = 4;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11   // decoded exactly like a word access
  } mem_size_e;

  // Byte-lane enables for an access of the given size at the given byte
  // offset (little-endian, lane 0 = bits 7:0).
  function automatic logic [3:0] lane_enables(input mem_size_e size,
                                              input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      MEM_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      MEM_BYTE: be = 4'b0001 << offset;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate sub-word store data across all lanes so that whichever lanes
  // are enabled pick up the right bytes without a shifter.
  function automatic logic [DATA_W-1:0] lane_data(input mem_size_e size,
                                                  input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] d;
    case (size)
      MEM_HALF: d = {2{data[15:0]}};
      MEM_BYTE: d = {4{data[7:0]}};
      default:  d = data;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bytelane
// Purpose  : Word-organised data memory built from four independent byte
//            lanes. Synchronous per-lane write, asynchronous read. Contents
//            are not initialised or cleared.
// Ports    : clk    - rising-edge write clock
//            we     - per-lane write enable (bit n -> bits 8n+7:8n)
//            addr   - word index
//            wdata  - write data (lane n taken from bits 8n+7:8n)
//            rdata  - asynchronous read of the addressed word
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bytelane #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // One array per lane keeps every storage element single-driven.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[l]) begin
        lane_mem[addr] <= wdata[8*l +: 8];
      end
    end

    assign rdata[8*l +: 8] = lane_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM stage of the 5-stage MIPS pipeline plus the MEM/WB pipeline
//            register. Resolves the branch decision combinationally, performs
//            byte/half/word accesses to an internal data memory and registers
//            everything write-back needs.
// Config   : MISALIGN_CHECK_EN - when defined, misaligned half/word accesses
//            suppress the store, return 0 and flag W_Misaligned. When
//            undefined, misaligned offset bits are ignored and W_Misaligned
//            is constant 0.
// Ports    : Clk, Reset (async, active-low)
//            M_*  - EX/MEM register outputs (control, addresses, data)
//            PCSrc/Flush/BranchTarget - combinational branch resolution
//            W_*  - MEM/WB register outputs
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(DMEM_DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [WB_W-1:0]       M_WB,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic                  M_Branch,
  input  logic                  M_BNE,
  input  logic                  M_BranchCon,
  input  logic [1:0]            M_MemSize,
  input  logic                  M_MemSigned,
  input  logic [DATA_W-1:0]     M_PCinc,
  input  logic [DATA_W-1:0]     M_BranchAddResult,
  input  logic [DATA_W-1:0]     M_ALUResult,
  input  logic [DATA_W-1:0]     M_WriteMemData,
  input  logic                  M_ZeroFlag,
  input  logic [REG_ADDR_W-1:0] M_WriteRegData,
  output logic                  PCSrc,
  output logic [DATA_W-1:0]     BranchTarget,
  output logic                  Flush,
  output logic [WB_W-1:0]       W_WB,
  output logic [DATA_W-1:0]     W_PCinc,
  output logic [DATA_W-1:0]     W_ReadData,
  output logic [DATA_W-1:0]     W_ALUResult,
  output logic [REG_ADDR_W-1:0] W_WriteRegData,
  output logic                  W_Misaligned
);

  // --------------------------------------------------------------------------
  // Branch resolution
  // --------------------------------------------------------------------------
  assign PCSrc        = (M_Branch & M_ZeroFlag) | (M_BNE & ~M_ZeroFlag) | M_BranchCon;
  assign Flush        = PCSrc;
  assign BranchTarget = M_BranchAddResult;

  // --------------------------------------------------------------------------
  // Address decode. Upper address bits are dropped so accesses wrap modulo
  // the memory depth.
  // --------------------------------------------------------------------------
  mem_size_e         size;
  logic [1:0]        offset;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;

  assign size     = mem_size_e'(M_MemSize);
  assign offset   = M_ALUResult[1:0];
  assign word_idx = M_ALUResult[ADDR_W+1:2];

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (M_MemRead | M_MemWrite) begin
      case (size)
        MEM_HALF: misaligned = offset[0];
        MEM_BYTE: misaligned = 1'b0;
        default:  misaligned = (offset != 2'b00);
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Data memory. Reset gates the write enable so a store that overlaps an
  // asserted reset is discarded even though the array itself has no reset.
  // --------------------------------------------------------------------------
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign mem_we    = (M_MemWrite & Reset & ~misaligned) ? lane_enables(size, offset) : 4'b0000;
  assign mem_wdata = lane_data(size, M_WriteMemData);

  dmem_bytelane #(
    .DEPTH  (DMEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk   (Clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Load extraction. The read is of the pre-store contents, so a combined
  // read+write returns the old word.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_shifted;
  logic [15:0]       rd_half;
  logic [7:0]        rd_byte;
  logic [DATA_W-1:0] load_val;

  assign rd_shifted = mem_rdata >> {offset, 3'b000};
  assign rd_byte    = rd_shifted[7:0];
  assign rd_half    = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (size)
      MEM_HALF: load_val = {{16{M_MemSigned & rd_half[15]}}, rd_half};
      MEM_BYTE: load_val = {{24{M_MemSigned & rd_byte[7]}}, rd_byte};
      default:  load_val = mem_rdata;
    endcase
    if (!M_MemRead || misaligned) begin
      load_val = '0;
    end
  end

  // --------------------------------------------------------------------------
  // MEM/WB pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      W_WB           <= '0;
      W_PCinc        <= '0;
      W_ReadData     <= '0;
      W_ALUResult    <= '0;
      W_WriteRegData <= '0;
      W_Misaligned   <= 1'b0;
    end else begin
      W_WB           <= M_WB;
      W_PCinc        <= M_PCinc;
      W_ReadData     <= load_val;
      W_ALUResult    <= M_ALUResult;
      W_WriteRegData <= M_WriteRegData;
      W_Misaligned   <= misaligned;
    end
  end

endmodule
`default_nettype wire
